// File: rtl/dec_done_gen_if.sv
// Handshake and status bundle between decoder control, the output stream and the
// block-completion tracker.
interface dec_done_gen_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_words;
  logic             out_vld;
  logic             out_rdy;
  logic             znz_last;
  logic             bpc_last;
  logic             last;
  logic             blk_done;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] words_left;

  modport master (
    output start, num_words, out_vld, out_rdy, znz_last, bpc_last,
    input  last, blk_done, busy, err, words_left
  );

  modport slave (
    input  start, num_words, out_vld, out_rdy, znz_last, bpc_last,
    output last, blk_done, busy, err, words_left
  );
endinterface

// File: rtl/dec_done_gen.sv
// Decoder block-completion tracker: counts handed-over words, marks the final one and
// pulses blk_done once words, ZNZ last and BPC last have all been observed.
module dec_done_gen #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic          clk_i,
  input logic          rst_ni,
  dec_done_gen_if.slave bus
);

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_LAST} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             znz_seen_q, znz_seen_d;
  logic             bpc_seen_q, bpc_seen_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic hs, znz_any, bpc_any, both_seen, dup_last;

  assign hs        = bus.out_vld & bus.out_rdy;
  assign znz_any   = znz_seen_q | bus.znz_last;
  assign bpc_any   = bpc_seen_q | bus.bpc_last;
  assign both_seen = znz_any & bpc_any;
  assign dup_last  = (bus.znz_last & znz_seen_q) | (bus.bpc_last & bpc_seen_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      znz_seen_q <= 1'b0;
      bpc_seen_q <= 1'b0;
      wd_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      znz_seen_q <= znz_seen_d;
      bpc_seen_q <= bpc_seen_d;
      wd_q       <= wd_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    znz_seen_d = znz_seen_q;
    bpc_seen_d = bpc_seen_q;
    wd_d       = wd_q;
    done_d     = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        // An accepted start clears the sticky error; a violation in the same cycle still wins.
        if (bus.start) begin
          err_d      = 1'b0;
          cnt_d      = bus.num_words;
          znz_seen_d = 1'b0;
          bpc_seen_d = 1'b0;
          if (bus.num_words == '0) done_d = 1'b1;
          else                     state_d = RUN;
        end
        if (hs | bus.znz_last | bus.bpc_last) err_d = 1'b1;
      end
      RUN: begin
        if (bus.start | dup_last) err_d = 1'b1;
        znz_seen_d = znz_any;
        bpc_seen_d = bpc_any;
        if (hs && cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (both_seen) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = WAIT_LAST;
              wd_d    = '0;
            end
          end
        end
      end
      WAIT_LAST: begin
        if (bus.start | dup_last | hs) err_d = 1'b1;
        znz_seen_d = znz_any;
        bpc_seen_d = bpc_any;
        if (both_seen) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (TIMEOUT_CYC != 0 && wd_q == WD_MAX) begin
          // Watchdog: a missing last pulse must not hang the decoder forever.
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.last       = (state_q == RUN) & bus.out_vld & (cnt_q == CNT_W'(1));
  assign bus.blk_done   = done_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.err        = err_q;
  assign bus.words_left = cnt_q;

endmodule

// File: tb/tb_dec_done_gen.sv
// Bench for dec_done_gen: directed block scenarios plus random traffic, compared each
// cycle against a block-level reference model.
module tb_dec_done_gen;
  localparam int CNT_W = 16;
  localparam int T     = 16;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  dec_done_gen_if #(.CNT_W(CNT_W)) bus ();

  dec_done_gen #(.CNT_W(CNT_W), .TIMEOUT_CYC(T)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: is a block open, how many words remain, which lasts arrived,
  // how long we have waited for the lasts after the final word.
  bit m_inblk, m_z, m_b, m_err, m_done;
  int m_left, m_waitc;
  bit last_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_inblk = 0; m_z = 0; m_b = 0; m_err = 0; m_done = 0; m_left = 0; m_waitc = 0;
  endtask

  task automatic step(input bit s, input int n, input bit v, input bit r, input bit z, input bit b);
    bit hs, zz, bb, nd, ne, ninblk, nz, nb;
    int nleft, nwait;
    @(negedge clk);
    bus.start = s; bus.num_words = CNT_W'(n); bus.out_vld = v; bus.out_rdy = r;
    bus.znz_last = z; bus.bpc_last = b;
    #1;
    last_seen = bus.last;
    chk("last",       {31'd0, bus.last},       {31'd0, m_inblk && m_left == 1 && v});
    chk("blk_done",   {31'd0, bus.blk_done},   {31'd0, m_done});
    chk("busy",       {31'd0, bus.busy},       {31'd0, m_inblk});
    chk("err",        {31'd0, bus.err},        {31'd0, m_err});
    chk("words_left", {16'd0, bus.words_left}, m_left);
    hs = v & r;
    nd = 0; ne = m_err; ninblk = m_inblk; nleft = m_left; nz = m_z; nb = m_b; nwait = m_waitc;
    if (!m_inblk) begin
      if (s) begin
        ne = 0; nleft = n; nz = 0; nb = 0;
        if (n == 0) nd = 1; else ninblk = 1;
      end
      if (hs | z | b) ne = 1;
    end else begin
      if (s || (z && m_z) || (b && m_b)) ne = 1;
      zz = m_z | z; bb = m_b | b;
      nz = zz; nb = bb;
      if (m_left > 0) begin
        if (hs) begin
          nleft = m_left - 1;
          if (nleft == 0) begin
            if (zz && bb) begin ninblk = 0; nd = 1; end
            else nwait = 0;
          end
        end
      end else begin
        if (hs) ne = 1;
        if (zz && bb) begin ninblk = 0; nd = 1; end
        else if (m_waitc == T - 1) begin ninblk = 0; nd = 1; ne = 1; end
        else nwait = m_waitc + 1;
      end
    end
    @(posedge clk);
    #1;
    m_inblk = ninblk; m_left = nleft; m_z = nz; m_b = nb; m_waitc = nwait;
    m_err = ne; m_done = nd;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.start = 0; bus.num_words = '0; bus.out_vld = 0; bus.out_rdy = 0;
    bus.znz_last = 0; bus.bpc_last = 0;
    rst_ni = 1'b0;
    #1;
    model_reset();
    chk("rst_last",       {31'd0, bus.last},       32'd0);
    chk("rst_blk_done",   {31'd0, bus.blk_done},   32'd0);
    chk("rst_busy",       {31'd0, bus.busy},       32'd0);
    chk("rst_err",        {31'd0, bus.err},        32'd0);
    chk("rst_words_left", {16'd0, bus.words_left}, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    int k;
    rst_ni = 1'b1;
    model_reset();
    do_reset();

    // 1: four words, lasts arrive during the run
    step(1, 4, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 0, 0);
    chk("t1_last_hs3", {31'd0, last_seen}, 32'd0);
    step(0, 0, 1, 1, 0, 1);
    chk("t1_last_hs4", {31'd0, last_seen}, 32'd1);
    chk("t1_done",     {31'd0, bus.blk_done}, 32'd1);
    chk("t1_err",      {31'd0, bus.err}, 32'd0);
    chk("t1_busy",     {31'd0, bus.busy}, 32'd0);
    idle(1);
    chk("t1_done_pulse", {31'd0, bus.blk_done}, 32'd0);

    // 2: lasts arrive after the words
    step(1, 3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0);
    chk("t2_wait_busy", {31'd0, bus.busy}, 32'd1);
    chk("t2_wait_left", {16'd0, bus.words_left}, 32'd0);
    idle(4);
    step(0, 0, 0, 0, 1, 0);
    idle(3);
    chk("t2_no_early_done", {31'd0, bus.blk_done}, 32'd0);
    step(0, 0, 0, 0, 0, 1);
    chk("t2_done", {31'd0, bus.blk_done}, 32'd1);
    chk("t2_err",  {31'd0, bus.err}, 32'd0);

    // 3: watchdog expiry
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    k = 0;
    while (!bus.blk_done && k < 40) begin
      step(0, 0, 0, 0, 0, 0);
      k++;
    end
    chk("t3_timeout_latency", k, 32'd16);
    chk("t3_err", {31'd0, bus.err}, 32'd1);

    // 4: zero-length block, then back-to-back start in the done cycle
    step(1, 0, 0, 0, 0, 0);
    chk("t4_done", {31'd0, bus.blk_done}, 32'd1);
    chk("t4_busy", {31'd0, bus.busy}, 32'd0);
    chk("t4_err_cleared", {31'd0, bus.err}, 32'd0);
    step(1, 2, 0, 0, 0, 0);
    chk("t4_busy2", {31'd0, bus.busy}, 32'd1);
    chk("t4_left",  {16'd0, bus.words_left}, 32'd2);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 0, 1);
    chk("t4_done2", {31'd0, bus.blk_done}, 32'd1);

    // 5: protocol violations are sticky but do not disturb the block
    step(1, 2, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0);
    chk("t5_err_start", {31'd0, bus.err}, 32'd1);
    chk("t5_left",      {16'd0, bus.words_left}, 32'd2);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("t5_done",      {31'd0, bus.blk_done}, 32'd1);
    chk("t5_err_stick", {31'd0, bus.err}, 32'd1);
    step(1, 1, 0, 0, 0, 0);
    chk("t5_err_clear", {31'd0, bus.err}, 32'd0);
    step(0, 0, 1, 1, 1, 1);
    chk("t5_done2", {31'd0, bus.blk_done}, 32'd1);
    chk("t5_err2",  {31'd0, bus.err}, 32'd0);

    // 6: reset in the middle of a block
    step(1, 5, 0, 0, 0, 0);
    chk("t6_left", {16'd0, bus.words_left}, 32'd5);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("t6_no_done", {31'd0, bus.blk_done}, 32'd0);
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 12) == 0, int'($urandom % 7), ($urandom % 2) == 1,
           ($urandom % 10) < 7, ($urandom % 14) == 0, ($urandom % 14) == 0);
      if (i == 1500) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
